poly_byte_encoder: RTL and testbench

- Inverse of the hash_top sampling path. hash_top turns a SHAKE byte stream into 256 coefficients; this block packs a 256-coefficient polynomial back into a byte stream.
- Implements Kyber ByteEncode_D (poly_tobytes for D=12; compressed-ciphertext packing for D<12).
- Takes the same 4096-bit lane format that hash_top emits: coefficient i in poly_in[16*i +: 16].
- Streams the packed result out as fixed-width words with valid/ready flow control, toward the SHAKE absorb path and the ciphertext/public-key output.

---
 rtl/poly_byte_encoder.sv | 129 ++++++++++++
 tb/tb_poly_byte_encoder.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_byte_encoder.sv
// Kyber ByteEncode_D: packs a 256-coefficient polynomial into a D-bit-per-coefficient
// LSB-first bit stream and emits it as OUT_W-bit words under valid/ready flow control.
module poly_byte_encoder #(
    parameter int D     = 12,
    parameter int OUT_W = 64,
    parameter int Q     = 3329
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4095:0]    poly_in,
    output logic             busy,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             done
);

    localparam int PW = 256 * D;
    localparam int NW = PW / OUT_W;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NW - 1);
    localparam logic [15:0]   Q16      = 16'(Q);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [PW-1:0]   stream_r;
    logic [PW-1:0]   packed_s;

    // D=12 lanes are signed residues in (-Q, Q) and are frozen into [0, Q);
    // narrower D lanes arrive already compressed.
    function automatic logic [D-1:0] condition_coef(input logic [15:0] lane);
        logic [15:0] frozen;
        if (lane[15]) begin
            frozen = lane + Q16;
        end else begin
            frozen = lane;
        end
        if (D == 12) begin
            return frozen[D-1:0];
        end else begin
            return lane[D-1:0];
        end
    endfunction

    // Concatenate the conditioned coefficients into the packed stream image.
    always_comb begin
        packed_s = '0;
        for (int i = 0; i < 256; i++) begin
            packed_s[D*i +: D] = condition_coef(poly_in[16*i +: 16]);
        end
    end

    // The low word of the stream register is always the word on offer, so each
    // accepted word shifts the next one into place.
    assign out_data = stream_r[OUT_W-1:0];

    // Control FSM, word counter and stream register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            stream_r  <= {PW{1'b0}};
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r   <= RUN;
                        stream_r  <= packed_s;
                        cnt_r     <= {CW{1'b0}};
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_last  <= (LAST_CNT == {CW{1'b0}});
                    end else begin
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        stream_r <= stream_r >> OUT_W;
                        if (cnt_r == LAST_CNT) begin
                            state_r   <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            cnt_r    <= cnt_r + CW'(1);
                            out_last <= ((cnt_r + CW'(1)) == LAST_CNT);
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                DONE: begin
                    state_r   <= IDLE;
                    cnt_r     <= {CW{1'b0}};
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    done      <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= {CW{1'b0}};
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_byte_encoder.sv
// Randomised bench for poly_byte_encoder (D=12 and D=4 builds) against a
// bit-level model of the ByteEncode stream.
module tb_poly_byte_encoder;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, start4, out_ready;
    logic [4095:0] poly_in, poly_in4;
    logic          busy, out_valid, out_last, done;
    logic [63:0]   out_data;
    logic          busy4, out_valid4, out_last4, done4;
    logic [63:0]   out_data4;

    int tests = 0;
    int fails = 0;

    logic [15:0] lanes [256];
    logic [63:0] got_words [$];
    bit          got_last [$];
    int          done_cyc, done_cnt, unstable, busy_bad;

    poly_byte_encoder #(.D(12), .OUT_W(64), .Q(3329)) dut (
        .clk(clk), .rst(rst), .start(start), .poly_in(poly_in), .busy(busy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done)
    );

    poly_byte_encoder #(.D(4), .OUT_W(64), .Q(3329)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .poly_in(poly_in4), .busy(busy4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
        .out_last(out_last4), .done(done4)
    );

    always #5 clk = ~clk;

    // Value of one coefficient after conditioning, from the arithmetic definition.
    function automatic int cond_coef(input logic [15:0] lane, input int d);
        int s;
        if (d == 12) begin
            s = $signed(lane);
            if (s < 0) s += 3329;
            return s % 4096;
        end
        return int'(lane) % (1 << d);
    endfunction

    // Word w of the stream: bit p of the stream is bit (p mod d) of coefficient p/d.
    function automatic logic [63:0] exp_word(input int d, input int w);
        logic [63:0] r;
        int p, v;
        r = '0;
        for (int b = 0; b < 64; b++) begin
            p = w * 64 + b;
            v = cond_coef(lanes[p / d], d);
            r[b] = ((v >> (p % d)) & 1) != 0;
        end
        return r;
    endfunction

    task automatic random_lanes();
        int v;
        for (int i = 0; i < 256; i++) begin
            v = int'($urandom_range(0, 6656)) - 3328;
            lanes[i] = v[15:0];
        end
    endtask

    task automatic load_poly(input bit sel);
        for (int i = 0; i < 256; i++) begin
            if (sel) poly_in4[16*i +: 16] = lanes[i];
            else     poly_in[16*i +: 16]  = lanes[i];
        end
    endtask

    // Called #1 after an edge: presents start for one cycle.
    task automatic kick(input bit sel);
        load_poly(sel);
        if (sel) start4 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start4 = 1'b0;
    endtask

    // Records the words handed over after an accepted start; cycle 1 is the
    // cycle right after acceptance. Ends 3 cycles after done or at a budget.
    task automatic collect(input bit sel, input int ready_mode, input bit inject);
        bit v, l, b, dn, prev_stall, prev_last;
        logic [63:0] dat, prev_dat;
        int after;
        got_words.delete();
        got_last.delete();
        done_cyc = -1; done_cnt = 0; unstable = 0; busy_bad = 0;
        prev_stall = 1'b0; prev_last = 1'b0; prev_dat = '0; after = 0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            v   = sel ? out_valid4 : out_valid;
            l   = sel ? out_last4  : out_last;
            b   = sel ? busy4      : busy;
            dn  = sel ? done4      : done;
            dat = sel ? out_data4  : out_data;
            if (inject && cyc == 5) begin
                if (sel) start4 = 1'b1; else start = 1'b1;
                for (int i = 0; i < 128; i++) begin
                    poly_in[32*i +: 32]  = $urandom();
                    poly_in4[32*i +: 32] = $urandom();
                end
            end
            if (inject && cyc == 6) begin
                start = 1'b0;
                start4 = 1'b0;
            end
            out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 1);
            if (prev_stall && (dat !== prev_dat || l !== prev_last || !v)) unstable++;
            if (done_cyc < 0) begin
                if (dn) begin
                    done_cyc = cyc;
                    done_cnt++;
                    if (b || v) busy_bad++;
                end else if (!b) begin
                    busy_bad++;
                end
            end else begin
                if (dn) done_cnt++;
                if (b || v) busy_bad++;
                after++;
                if (after >= 3) break;
            end
            if (v && out_ready) begin
                got_words.push_back(dat);
                got_last.push_back(l);
            end
            prev_stall = v && !out_ready;
            prev_dat = dat;
            prev_last = l;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; start4 = 1'b0; out_ready = 1'b1;
        poly_in = '0; poly_in4 = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, out_valid, out_last, done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, out_valid, out_last, done});
        end
        tests++;
        if (out_data !== 64'h0) begin
            fails++;
            $display("FAIL reset_data: got %h expected 0", out_data);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: valid %b busy %b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_zero();
        for (int i = 0; i < 256; i++) lanes[i] = 16'h0000;
        kick(1'b0);
        collect(1'b0, 0, 1'b0);
        tests++;
        if (got_words.size() != 48) begin
            fails++;
            $display("FAIL zero_count: got %0d expected 48", got_words.size());
        end
        for (int w = 0; w < got_words.size() && w < 48; w++) begin
            tests++;
            if (got_words[w] !== 64'h0 || got_last[w] !== (w == 47)) begin
                fails++;
                $display("FAIL zero_word%0d: got %h last %b expected 0 last %b", w, got_words[w], got_last[w], w == 47);
            end
        end
        tests++;
        if (done_cyc != 49 || done_cnt != 1) begin
            fails++;
            $display("FAIL zero_done: got cycle %0d pulses %0d expected 49 1", done_cyc, done_cnt);
        end
        tests++;
        if (busy_bad != 0) begin
            fails++;
            $display("FAIL zero_busy: got %0d bad cycles expected 0", busy_bad);
        end
    endtask

    task automatic test_directed();
        for (int i = 0; i < 256; i++) lanes[i] = 16'h0000;
        lanes[0] = 16'd2737;
        lanes[1] = 16'd551;
        kick(1'b0);
        collect(1'b0, 0, 1'b0);
        tests++;
        if (got_words.size() != 48 || got_words[0] !== 64'h0000000000227AB1) begin
            fails++;
            $display("FAIL directed_word0: got %h (n=%0d) expected 0000000000227ab1", got_words[0], got_words.size());
        end
        for (int w = 1; w < got_words.size() && w < 48; w++) begin
            tests++;
            if (got_words[w] !== 64'h0) begin
                fails++;
                $display("FAIL directed_word%0d: got %h expected 0", w, got_words[w]);
            end
        end
    endtask

    task automatic test_negative();
        for (int i = 0; i < 256; i++) lanes[i] = 16'h0000;
        lanes[0] = 16'hFFFF;
        lanes[5] = 16'hF300;
        kick(1'b0);
        collect(1'b0, 0, 1'b0);
        tests++;
        if (got_words.size() != 48) begin
            fails++;
            $display("FAIL neg_count: got %0d expected 48", got_words.size());
        end else begin
            tests++;
            if (got_words[0][11:0] !== 12'hD00 || got_words[0][63:60] !== 4'h1 || got_words[1][7:0] !== 8'h00) begin
                fails++;
                $display("FAIL neg_fields: got w0 %h w1 %h expected w0[11:0]=d00 w0[63:60]=1 w1[7:0]=00", got_words[0], got_words[1]);
            end
            for (int w = 0; w < 48; w++) begin
                tests++;
                if (got_words[w] !== exp_word(12, w)) begin
                    fails++;
                    $display("FAIL neg_word%0d: got %h expected %h", w, got_words[w], exp_word(12, w));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int job = 0; job < 3; job++) begin
            random_lanes();
            kick(1'b0);
            collect(1'b0, 0, 1'b0);
            tests++;
            if (got_words.size() != 48 || done_cyc != 49) begin
                fails++;
                $display("FAIL rand%0d_len: got %0d words done %0d expected 48 49", job, got_words.size(), done_cyc);
            end
            for (int w = 0; w < got_words.size() && w < 48; w++) begin
                tests++;
                if (got_words[w] !== exp_word(12, w) || got_last[w] !== (w == 47)) begin
                    fails++;
                    $display("FAIL rand%0d_word%0d: got %h last %b expected %h", job, w, got_words[w], got_last[w], exp_word(12, w));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        random_lanes();
        kick(1'b0);
        collect(1'b0, 1, 1'b1);
        tests++;
        if (unstable != 0) begin
            fails++;
            $display("FAIL bp_stable: got %0d unstable stalls expected 0", unstable);
        end
        tests++;
        if (got_words.size() != 48 || done_cnt != 1 || busy_bad != 0) begin
            fails++;
            $display("FAIL bp_len: got %0d words %0d pulses %0d busy errs expected 48 1 0", got_words.size(), done_cnt, busy_bad);
        end
        for (int w = 0; w < got_words.size() && w < 48; w++) begin
            tests++;
            if (got_words[w] !== exp_word(12, w) || got_last[w] !== (w == 47)) begin
                fails++;
                $display("FAIL bp_word%0d: got %h last %b expected %h", w, got_words[w], got_last[w], exp_word(12, w));
            end
        end
    endtask

    task automatic test_d4();
        for (int i = 0; i < 256; i++) lanes[i] = 16'(i % 16);
        kick(1'b1);
        collect(1'b1, 0, 1'b0);
        tests++;
        if (got_words.size() != 16 || done_cyc != 17) begin
            fails++;
            $display("FAIL d4_len: got %0d words done %0d expected 16 17", got_words.size(), done_cyc);
        end
        for (int w = 0; w < got_words.size() && w < 16; w++) begin
            tests++;
            if (got_words[w] !== 64'hFEDCBA9876543210 || got_words[w] !== exp_word(4, w) || got_last[w] !== (w == 15)) begin
                fails++;
                $display("FAIL d4_word%0d: got %h last %b expected fedcba9876543210 last %b", w, got_words[w], got_last[w], w == 15);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int dseen;
        random_lanes();
        kick(1'b0);
        out_ready = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({out_valid, busy, done} !== 3'b000 || out_data !== 64'h0) begin
            fails++;
            $display("FAIL rst_mid: got valid %b busy %b done %b data %h expected 0 0 0 0", out_valid, busy, done, out_data);
        end
        rst = 1'b1;
        dseen = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done || out_valid) dseen++;
        end
        tests++;
        if (dseen != 0) begin
            fails++;
            $display("FAIL rst_no_done: got %0d active cycles expected 0", dseen);
        end
        kick(1'b0);
        collect(1'b0, 0, 1'b0);
        tests++;
        if (got_words.size() != 48 || done_cyc != 49) begin
            fails++;
            $display("FAIL rst_restart_len: got %0d words done %0d expected 48 49", got_words.size(), done_cyc);
        end
        for (int w = 0; w < got_words.size() && w < 48; w++) begin
            tests++;
            if (got_words[w] !== exp_word(12, w)) begin
                fails++;
                $display("FAIL rst_restart_word%0d: got %h expected %h", w, got_words[w], exp_word(12, w));
            end
        end
    endtask

    task automatic test_back_to_back();
        int waited;
        random_lanes();
        kick(1'b0);
        out_ready = 1'b1;
        waited = 0;
        while (!done && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL b2b_first_done: got no done within %0d cycles expected done", waited);
        end
        random_lanes();
        load_poly(1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_ignored: got valid %b busy %b expected 0 0", out_valid, busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accepted: got valid %b busy %b expected 1 1", out_valid, busy);
        end
        collect(1'b0, 0, 1'b0);
        tests++;
        if (got_words.size() != 48 || done_cyc != 49) begin
            fails++;
            $display("FAIL b2b_len: got %0d words done %0d expected 48 49", got_words.size(), done_cyc);
        end
        for (int w = 0; w < got_words.size() && w < 48; w++) begin
            tests++;
            if (got_words[w] !== exp_word(12, w)) begin
                fails++;
                $display("FAIL b2b_word%0d: got %h expected %h", w, got_words[w], exp_word(12, w));
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_directed();
        test_negative();
        test_random();
        test_backpressure();
        test_d4();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
